// File: rtl/fifo_word_reader_if.sv
// Handshake bundle between the byte FIFO read port, the word reader and the FP operand input.
// The master modport is the reader; the slave modport is the FIFO plus downstream consumer.
interface fifo_word_reader_if #(
  parameter int BYTES_PER_WORD = 4
) ();
  logic                          fifo_empty;
  logic [7:0]                    fifo_data;
  logic                          fifo_rd_en;
  logic [8*BYTES_PER_WORD-1:0]   word_out;
  logic                          word_valid;
  logic                          word_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en,
    output word_out,
    output word_valid,
    input  word_ready
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en,
    input  word_out,
    input  word_valid,
    output word_ready
  );
endinterface

// File: rtl/fifo_word_reader.sv
// Pops bytes from the byte FIFO, assembles BYTES_PER_WORD of them into one operand word
// and offers it downstream on a valid/ready handshake. One pop is outstanding at most.
module fifo_word_reader #(
  parameter int BYTES_PER_WORD = 4,
  parameter bit BIG_ENDIAN     = 1'b1,
  localparam int IDX_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1,
  localparam int WORD_W = 8 * BYTES_PER_WORD
) (
  input  logic                  clk,
  input  logic                  reset,
  fifo_word_reader_if.master    bus,
  output logic [IDX_W-1:0]      byte_idx,
  output logic [7:0]            words_done
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_CAPTURE = 2'd1,
    S_HOLD    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   asm_q, asm_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                valid_q, valid_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [7:0]          done_q, done_d;
  logic                rd_en;

  function automatic logic [WORD_W-1:0] shift_in(input logic [WORD_W-1:0] acc,
                                                 input logic [7:0]        b);
    if (BIG_ENDIAN) return {acc[WORD_W-9:0], b};
    else            return {b, acc[WORD_W-1:8]};
  endfunction

  always_comb begin
    state_d = state_q;
    asm_d   = asm_q;
    word_d  = word_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    done_d  = done_q;
    rd_en   = 1'b0;
    case (state_q)
      S_REQ: begin
        if (!bus.fifo_empty && !reset) begin
          rd_en   = 1'b1;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        // The FIFO's registered data is valid exactly one cycle after the pop.
        asm_d = shift_in(asm_q, bus.fifo_data);
        if (idx_q == IDX_W'(BYTES_PER_WORD - 1)) begin
          word_d  = asm_d;
          valid_d = 1'b1;
          idx_d   = '0;
          state_d = S_HOLD;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (valid_q && bus.word_ready) begin
          valid_d = 1'b0;
          done_d  = done_q + 8'd1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      asm_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      done_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      asm_q   <= asm_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;
  assign byte_idx       = idx_q;
  assign words_done     = done_q;

endmodule

// File: tb/tb_fifo_word_reader.sv
// Directed bench: a big-endian and a little-endian reader share one modelled byte FIFO
// and run in lockstep, so every word is checked in both byte orders.
module tb_fifo_word_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       fifo_flush;
  logic [1:0] idx_be, idx_le;
  logic [7:0] done_be, done_le;

  logic [7:0] mem [0:2047];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  int checks = 0;
  int errors = 0;

  fifo_word_reader_if #(.BYTES_PER_WORD(4)) bus_be ();
  fifo_word_reader_if #(.BYTES_PER_WORD(4)) bus_le ();

  fifo_word_reader #(.BYTES_PER_WORD(4), .BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .reset(reset), .bus(bus_be), .byte_idx(idx_be), .words_done(done_be)
  );
  fifo_word_reader #(.BYTES_PER_WORD(4), .BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .reset(reset), .bus(bus_le), .byte_idx(idx_le), .words_done(done_le)
  );

  always #5 clk = ~clk;

  // Byte FIFO model with registered read data; the LE reader mirrors the BE reader's pops.
  assign bus_be.fifo_empty = (wr_ptr == rd_ptr);
  assign bus_le.fifo_empty = bus_be.fifo_empty;
  assign bus_le.fifo_data  = bus_be.fifo_data;
  assign bus_le.word_ready = bus_be.word_ready;

  initial bus_be.fifo_data = 8'h00;

  always @(posedge clk) begin
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (bus_be.fifo_rd_en && (rd_ptr != wr_ptr)) begin
      bus_be.fifo_data <= mem[rd_ptr];
      rd_ptr           <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr++;
  endtask

  task automatic push4(input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    push(b0); push(b1); push(b2); push(b3);
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (bus_be.word_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic chk_word(input string tag, input logic [31:0] be, input logic [31:0] le);
    chk({tag, "_be"}, 64'(bus_be.word_out), 64'(be));
    chk({tag, "_le"}, 64'(bus_le.word_out), 64'(le));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] sb_be [0:255];
  logic [31:0] sb_le [0:255];
  logic [7:0]  exp_done;
  int          n;

  initial begin
    reset             = 1'b1;
    fifo_flush        = 1'b0;
    bus_be.word_ready = 1'b0;

    // Reset with data waiting: no pop may be requested.
    step();
    push4(8'h3F, 8'h80, 8'h00, 8'h00);
    #1;
    chk("rst_rd_en", 64'(bus_be.fifo_rd_en), 64'd0);
    step();
    chk("rst_word",  64'(bus_be.word_out),   64'd0);
    chk("rst_valid", 64'(bus_be.word_valid), 64'd0);
    chk("rst_idx",   64'(idx_be),            64'd0);
    chk("rst_done",  64'(done_be),           64'd0);

    // First word, ready held high.
    reset             = 1'b0;
    bus_be.word_ready = 1'b1;
    #1;
    chk("first_pop", 64'(bus_be.fifo_rd_en), 64'd1);
    wait_valid(30, n);
    chk("first_latency", 64'(n), 64'd8);
    chk_word("w1", 32'h3F800000, 32'h0000803F);
    step();
    chk("w1_valid_pulse", 64'(bus_be.word_valid), 64'd0);
    chk("w1_done",        64'(done_be),           64'd1);

    // Two bytes, then an empty gap.
    push(8'h40); push(8'h49);
    #1;
    repeat (4) step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("gap_idx",   64'(idx_be),            64'd2);
      chk("gap_rd_en", 64'(bus_be.fifo_rd_en), 64'd0);
    end
    push(8'h0F); push(8'hDB);
    #1;
    wait_valid(30, n);
    chk("gap_resume_latency", 64'(n), 64'd4);
    chk_word("w2", 32'h40490FDB, 32'hDB0F4940);
    step();
    chk("w2_done", 64'(done_be), 64'd2);

    // Backpressure with the next word already queued.
    bus_be.word_ready = 1'b0;
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    push4(8'h55, 8'h66, 8'h77, 8'h88);
    #1;
    wait_valid(30, n);
    chk("bp_latency", 64'(n), 64'd8);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("bp_valid", 64'(bus_be.word_valid), 64'd1);
      chk("bp_word",  64'(bus_be.word_out),   64'h11223344);
      chk("bp_rd_en", 64'(bus_be.fifo_rd_en), 64'd0);
    end
    bus_be.word_ready = 1'b1;
    step();
    chk("bp_release_valid", 64'(bus_be.word_valid), 64'd0);
    wait_valid(30, n);
    chk("bp_next_latency", 64'(n + 1), 64'd9);
    chk_word("w4", 32'h55667788, 32'h88776655);
    step();
    chk("w4_done", 64'(done_be), 64'd4);

    // Reset after two of four bytes captured.
    push4(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    #1;
    repeat (4) step();
    chk("mid_idx", 64'(idx_be), 64'd2);
    reset      = 1'b1;
    fifo_flush = 1'b1;
    #1;
    chk("mid_rst_rd_en", 64'(bus_be.fifo_rd_en), 64'd0);
    step();
    chk("mid_rst_word",  64'(bus_be.word_out),   64'd0);
    chk("mid_rst_valid", 64'(bus_be.word_valid), 64'd0);
    chk("mid_rst_idx",   64'(idx_be),            64'd0);
    chk("mid_rst_done",  64'(done_be),           64'd0);
    reset      = 1'b0;
    fifo_flush = 1'b0;
    push4(8'h01, 8'h02, 8'h03, 8'h04);
    #1;
    wait_valid(30, n);
    chk("fresh_latency", 64'(n), 64'd8);
    chk_word("fresh", 32'h01020304, 32'h04030201);
    step();
    chk("fresh_done", 64'(done_be), 64'd1);

    // 256-word stream against a push-order scoreboard; words_done wraps.
    for (int w = 0; w < 256; w++) begin
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'(w);
      b1 = 8'(w) ^ 8'hA5;
      b2 = ~8'(w);
      b3 = 8'(w) + 8'd7;
      push4(b0, b1, b2, b3);
      sb_be[w] = {b0, b1, b2, b3};
      sb_le[w] = {b3, b2, b1, b0};
    end
    #1;
    exp_done = 8'd1;
    for (int w = 0; w < 256; w++) begin
      wait_valid(30, n);
      chk("stream_period", 64'(n), 64'd8);
      chk_word("stream", sb_be[w], sb_le[w]);
      step();
      exp_done = exp_done + 8'd1;
      chk("stream_done", 64'(done_be), 64'(exp_done));
    end
    chk("stream_le_done", 64'(done_le), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_word_reader.md
# fifo_word_reader

Read-side consumer for the 8-bit byte FIFO. It pops bytes and assembles groups of BYTES_PER_WORD bytes into one IEEE-754 operand word. It presents each word to the FP processor core on a valid/ready handshake. It sits between the byte FIFO's read port (rd_en / empty / data_out) and the operand input of the FP datapath, and exposes its byte index for LED mapping.

## Interface
- BYTES_PER_WORD, default 4: bytes per assembled word; legal values 2..8.
- BIG_ENDIAN, default 1: 1 = first popped byte lands in the word MSB; 0 = first popped byte lands in the LSB.
- clk  input  1  sole clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- fifo_empty  input  1  FIFO empty flag.
- fifo_data  input  8  FIFO registered read data; valid the cycle after a pop.
- fifo_rd_en  output  1  pop request to the FIFO (combinational).
- word_out  output  8*BYTES_PER_WORD  assembled word; registered.
- word_valid  output  1  word_out holds a complete word; registered.
- word_ready  input  1  downstream accepts word_out this cycle.
- byte_idx  output  clog2(BYTES_PER_WORD)  index of the next byte to capture (LED mapping); registered.
- words_done  output  8  count of accepted words; wraps 255 -> 0.

## Operation
- FSM states:
  - REQ: issue a pop.
  - CAPTURE: sample the popped byte.
  - HOLD: present the word and wait for acceptance.
- REQ:
  - fifo_rd_en = !fifo_empty && !reset.
  - If a pop is issued, go to CAPTURE; otherwise stay in REQ.
- CAPTURE:
  - fifo_rd_en = 0.
  - Shift fifo_data into the assembly register.
    - BIG_ENDIAN=1: shift the register left 8 bits and insert the byte at [7:0].
    - BIG_ENDIAN=0: shift the register right 8 bits and insert the byte at the top byte.
  - If byte_idx == BYTES_PER_WORD-1, go to HOLD, set word_valid, and reset byte_idx to 0.
  - Otherwise increment byte_idx and go to REQ.
- HOLD:
  - fifo_rd_en = 0; word_out and word_valid stay stable.
  - When word_valid && word_ready at a clock edge: clear word_valid, increment words_done (mod 256), go to REQ.
- Only one pop is outstanding at any time, so the FIFO can never be over-read.
- word_out changes only on the edge that completes a word. The partially assembled value lives in an internal register, not in word_out.
- byte_idx never exceeds BYTES_PER_WORD-1.

## Timing
- Reset state (on the edge where reset=1):
  - FSM goes to REQ.
  - word_out = 0, word_valid = 0, byte_idx = 0, words_done = 0.
  - The internal assembly register is cleared.
  - fifo_rd_en is 0 in every cycle where reset=1.
- Reset mid-word or mid-HOLD: any partial or pending word is discarded and no handshake is counted. Bytes already popped are lost; the FIFO must be reset alongside.
- Per byte: 2 cycles (REQ with pop, then CAPTURE), assuming the FIFO is non-empty.
- Latency: the first pop cycle to word_valid=1 takes 2*BYTES_PER_WORD cycles (8 for the default).
- Throughput: 2*BYTES_PER_WORD + 1 cycles per word when word_ready is held high. A pop may be issued in the cycle immediately after the accepting edge.
- Empty FIFO in REQ: the FSM stalls with no pop and byte_idx unchanged. It resumes the cycle fifo_empty falls.
- Backpressure: word_ready low in HOLD causes an indefinite stall. No pops are issued and word_out is held bit-stable.
- word_ready high outside HOLD is ignored.

## Test plan
- Push 0x3F,0x80,0x00,0x00 with BIG_ENDIAN=1 and word_ready=1 -> word_out = 0x3F800000 and word_valid high for exactly 1 cycle, 8 cycles after the first fifo_rd_en; words_done = 1.
- Same bytes with BIG_ENDIAN=0 -> word_out = 0x0000803F.
- Push 0x40,0x49 only, wait 10 cycles, then push 0x0F,0xDB -> byte_idx holds at 2 during the gap with fifo_rd_en = 0; then word_out = 0x40490FDB.
- Deliver a complete word with word_ready=0 for 6 cycles and the FIFO holding 4 more bytes -> word_out stable and fifo_rd_en = 0 for all 6 cycles. The next word completes 9 cycles after word_ready rises.
- Pulse reset after 2 of 4 bytes are captured -> all outputs return to reset values. The next 4 bytes form a fresh word with no leftover bytes.
- Stream 256 words -> words_done wraps 255 -> 0; no dropped or duplicated bytes, checked by a scoreboard against the push order.
